// File: rtl/matrix_scan_capture.sv
// Receive side of the LED-matrix scan link: filters the multiplexed row/col
// drive lines and rebuilds a gs x gs frame, committed atomically on completion.
module matrix_scan_capture #(
    parameter int unsigned gs      = 8,
    parameter int unsigned STABLE  = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 e_cap_i,
    input  logic [gs-1:0]        col_val_i,
    input  logic [gs-1:0]        row_val_i,
    output logic [gs*gs-1:0]     matrix_o,
    output logic                 d_cap_o,
    output logic                 err_o,
    output logic [7:0]           frame_cnt_o
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned SW = $clog2(STABLE + 1);
    localparam int unsigned RW = (gs > 1) ? $clog2(gs) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_COMMIT,
        S_DONE,
        S_DONE_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [gs-1:0]    prev_row_q, prev_col_q;
    logic [SW-1:0]    stab_q, stab_d;
    logic [TW-1:0]    tmo_q;
    logic [gs-1:0]    mask_q;
    logic [gs-1:0]    shadow_q [gs];

    logic             scan_c, start_c, commit_c;
    logic             same_c, accept_c;
    logic             row_zero_c, row_onehot_c;
    logic [RW-1:0]    row_idx_c;
    logic             mask_full_c, tmo_hit_c, tmo_evt_c, multi_c;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; dropping enable aborts a frame from any state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (e_cap_i) state_d = S_SCAN;
            S_SCAN: begin
                if (!e_cap_i)         state_d = S_IDLE;
                else if (mask_full_c) state_d = S_COMMIT;
            end
            S_COMMIT:    state_d = S_DONE;
            S_DONE:      state_d = e_cap_i ? S_DONE_HOLD : S_IDLE;
            S_DONE_HOLD: state_d = e_cap_i ? S_SCAN : S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Control strobes decoded from state
    always_comb begin
        scan_c   = (state_q == S_SCAN);
        commit_c = (state_q == S_COMMIT);
        start_c  = e_cap_i && ((state_q == S_IDLE) || (state_q == S_DONE_HOLD));
    end

    // Row decode: one-hot check and lowest-index priority encoder
    always_comb begin
        row_zero_c   = (row_val_i == '0);
        row_onehot_c = !row_zero_c && ((row_val_i & (row_val_i - gs'(1))) == '0);
        row_idx_c    = '0;
        for (int i = int'(gs) - 1; i >= 0; i--) begin
            if (row_val_i[i]) row_idx_c = RW'(i);
        end
    end

    // Stability filter: accept once when an unchanged pair reaches STABLE cycles
    always_comb begin
        same_c = (row_val_i == prev_row_q) && (col_val_i == prev_col_q);
        if (same_c) stab_d = (stab_q == SW'(STABLE)) ? stab_q : stab_q + SW'(1);
        else        stab_d = SW'(1);
        accept_c    = scan_c && (stab_d == SW'(STABLE)) && !(same_c && (stab_q == SW'(STABLE)));
        mask_full_c = &mask_q;
        tmo_hit_c   = (tmo_q == TW'(TIMEOUT - 1));
        tmo_evt_c   = scan_c && e_cap_i && !mask_full_c && tmo_hit_c;
        multi_c     = accept_c && !row_zero_c && !row_onehot_c;
    end

    // Previous-pair and run-length registers; the run restarts outside SCAN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_row_q <= '0;
            prev_col_q <= '0;
            stab_q     <= '0;
        end else begin
            prev_row_q <= row_val_i;
            prev_col_q <= col_val_i;
            stab_q     <= scan_c ? stab_d : '0;
        end
    end

    // Shadow frame, captured-row mask and frame timeout counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mask_q <= '0;
            tmo_q  <= '0;
            for (int r = 0; r < int'(gs); r++) shadow_q[r] <= '0;
        end else if (start_c) begin
            mask_q <= '0;
            tmo_q  <= '0;
        end else if (commit_c) begin
            tmo_q  <= '0;
        end else if (scan_c) begin
            if (accept_c && row_onehot_c) shadow_q[row_idx_c] <= col_val_i;
            if (tmo_evt_c) begin
                mask_q <= '0;
                tmo_q  <= '0;
            end else begin
                tmo_q <= tmo_q + TW'(1);
                if (accept_c && row_onehot_c) mask_q[row_idx_c] <= 1'b1;
            end
        end
    end

    // Registered outputs: atomic frame commit, done pulse, counter, sticky error
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            matrix_o    <= '0;
            d_cap_o     <= 1'b0;
            err_o       <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            d_cap_o <= commit_c;
            if (commit_c) begin
                for (int r = 0; r < int'(gs); r++) matrix_o[r*gs +: gs] <= shadow_q[r];
                frame_cnt_o <= frame_cnt_o + 8'd1;
            end
            if (tmo_evt_c || multi_c) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Directed bench for matrix_scan_capture with a frame-level reference model.
module tb_matrix_scan_capture;

    localparam int unsigned GS = 8;
    localparam int unsigned ST = 2;
    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        e_cap_i = 1'b0;
    logic [7:0]  col_val_i = 8'h00;
    logic [7:0]  row_val_i = 8'h00;
    logic [63:0] matrix_o;
    logic        d_cap_o;
    logic        err_o;
    logic [7:0]  frame_cnt_o;

    always #5 clk = ~clk;

    matrix_scan_capture #(.gs(GS), .STABLE(ST), .TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .e_cap_i     (e_cap_i),
        .col_val_i   (col_val_i),
        .row_val_i   (row_val_i),
        .matrix_o    (matrix_o),
        .d_cap_o     (d_cap_o),
        .err_o       (err_o),
        .frame_cnt_o (frame_cnt_o)
    );

    int checks  = 0;
    int errors  = 0;
    int dcap_hi = 0;

    // Reference model state (frame-level view of the capture rules)
    bit          m_valid    = 1'b0;
    bit          m_scanning = 1'b0;
    int          m_post     = 0;   // cycles into the commit/done sequence
    int          m_run      = 0;   // length of the current run of identical samples
    logic [15:0] m_prev     = 16'h0;
    int          m_tcyc     = 0;   // cycles spent on the current frame attempt
    logic [7:0]  m_seen     = 8'h00;
    logic [7:0]  m_shadow [8];
    logic [63:0] exp_matrix = 64'h0;
    int          exp_cnt    = 0;
    bit          exp_err    = 1'b0;
    bit          exp_dcap   = 1'b0;

    task start_scan();
        m_scanning = 1'b1;
        m_seen     = 8'h00;
        m_tcyc     = 0;
        m_run      = 0;
    endtask

    // Model update on each rising edge from the inputs seen before it
    always @(posedge clk) begin
        logic [15:0] pair;
        bit          full_before;
        int          idx;
        if (reset_i) begin
            m_valid = 1'b1; m_scanning = 1'b0; m_post = 0; m_run = 0;
            m_seen = 8'h00; exp_matrix = 64'h0; exp_cnt = 0;
            exp_err = 1'b0; exp_dcap = 1'b0;
            for (int r = 0; r < 8; r++) m_shadow[r] = 8'h00;
        end else if (m_valid) begin
            if (m_post == 1) begin
                for (int r = 0; r < 8; r++) exp_matrix[r*8 +: 8] = m_shadow[r];
                exp_cnt  = (exp_cnt + 1) % 256;
                exp_dcap = 1'b1;
                m_post   = 2;
            end else if (m_post == 2) begin
                exp_dcap = 1'b0;
                m_post   = e_cap_i ? 3 : 0;
            end else if (m_post == 3) begin
                if (e_cap_i) start_scan();
                m_post = 0;
            end else if (!m_scanning) begin
                if (e_cap_i) start_scan();
            end else begin
                full_before = (m_seen == 8'hFF);
                pair = {row_val_i, col_val_i};
                if (m_run == 0 || pair != m_prev) m_run = 1;
                else                              m_run = m_run + 1;
                m_prev = pair;
                if (m_run == int'(ST)) begin
                    if ($countones(row_val_i) == 1) begin
                        idx = 0;
                        for (int r = 0; r < 8; r++) if (row_val_i[r]) idx = r;
                        m_shadow[idx] = col_val_i;
                        m_seen[idx]   = 1'b1;
                    end else if (row_val_i != 8'h00) begin
                        exp_err = 1'b1;
                    end
                end
                m_tcyc = m_tcyc + 1;
                if (e_cap_i && !full_before && m_tcyc == int'(TO)) begin
                    exp_err = 1'b1;
                    m_seen  = 8'h00;
                    m_tcyc  = 0;
                end
                if (!e_cap_i) m_scanning = 1'b0;
                else if (full_before) begin
                    m_scanning = 1'b0;
                    m_post     = 1;
                end
            end
        end
    end

    task chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model
    task tick();
        @(negedge clk);
        if (m_valid) begin
            chk("matrix_o",    matrix_o,             exp_matrix);
            chk("frame_cnt_o", 64'(frame_cnt_o),     64'(exp_cnt));
            chk("err_o",       64'(err_o),           64'(exp_err));
            chk("d_cap_o",     64'(d_cap_o),         64'(exp_dcap));
            if (d_cap_o === 1'b1) dcap_hi = dcap_hi + 1;
        end
    endtask

    task drive(input logic [7:0] r, input logic [7:0] c, input int n);
        repeat (n) begin
            tick();
            row_val_i = r;
            col_val_i = c;
        end
    endtask

    task en_blank(input logic v, input int n);
        repeat (n) begin
            tick();
            e_cap_i   = v;
            row_val_i = 8'h00;
            col_val_i = 8'h00;
        end
    endtask

    task frame(input logic [7:0] base, input int first, input int last, input int hold);
        for (int r = first; r <= last; r++) drive(8'(1 << r), base ^ 8'(r), hold);
    endtask

    task pulse_reset();
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
    endtask

    task lit_zero(input string tag);
        chk({tag, "_matrix"}, matrix_o, 64'h0);
        chk({tag, "_cnt"},    64'(frame_cnt_o), 64'd0);
        chk({tag, "_err"},    64'(err_o), 64'd0);
        chk({tag, "_dcap"},   64'(d_cap_o), 64'd0);
    endtask

    initial begin
        // Power-on reset
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        lit_zero("reset");

        // Full frame, rows held 3 cycles, col = A5^r
        en_blank(1'b1, 1);
        frame(8'hA5, 0, 7, 3);
        en_blank(1'b1, 5);
        chk("f1_matrix", matrix_o, 64'hA2A3A0A1A6A7A4A5);
        chk("f1_cnt",    64'(frame_cnt_o), 64'd1);
        chk("f1_err",    64'(err_o), 64'd0);
        chk("f1_pulses", 64'(dcap_hi), 64'd1);
        en_blank(1'b0, 3);

        // Row 3 shown for a single cycle: no commit until re-presented
        en_blank(1'b1, 1);
        frame(8'h3C, 0, 2, 3);
        drive(8'h08, 8'h3F, 1);
        frame(8'h3C, 4, 7, 3);
        en_blank(1'b1, 4);
        chk("short_row_no_commit", 64'(dcap_hi), 64'd1);
        chk("short_row_cnt",       64'(frame_cnt_o), 64'd1);
        drive(8'h08, 8'h3F, 2);
        en_blank(1'b1, 5);
        chk("short_row_matrix", matrix_o, 64'h3B3A39383F3E3D3C);
        chk("short_row_pulses", 64'(dcap_hi), 64'd2);
        en_blank(1'b0, 3);

        // Multi-hot row mid-frame: sticky error, frame still commits
        en_blank(1'b1, 1);
        frame(8'h5A, 0, 3, 2);
        drive(8'h18, 8'hFF, 2);
        frame(8'h5A, 4, 7, 2);
        en_blank(1'b1, 5);
        chk("multi_err",    64'(err_o), 64'd1);
        chk("multi_matrix", matrix_o, 64'h5D5C5F5E59585B5A);
        chk("multi_cnt",    64'(frame_cnt_o), 64'd3);
        en_blank(1'b0, 3);
        pulse_reset();
        lit_zero("clear_err");

        // Timeout: only rows 0..6 after a good frame
        en_blank(1'b1, 1);
        frame(8'h11, 0, 7, 2);
        en_blank(1'b1, 5);
        en_blank(1'b0, 3);
        en_blank(1'b1, 1);
        frame(8'h22, 0, 6, 3);
        en_blank(1'b1, 50);
        chk("tmo_err",    64'(err_o), 64'd1);
        chk("tmo_matrix", matrix_o, 64'h1617141512131011);
        chk("tmo_cnt",    64'(frame_cnt_o), 64'd1);
        frame(8'h77, 0, 7, 2);
        en_blank(1'b1, 5);
        chk("tmo_recover_matrix", matrix_o, 64'h7071727374757677);
        chk("tmo_recover_cnt",    64'(frame_cnt_o), 64'd2);
        en_blank(1'b0, 3);

        // Enable dropped after 4 rows, then a fresh frame
        en_blank(1'b1, 1);
        frame(8'hC3, 0, 3, 2);
        en_blank(1'b0, 3);
        en_blank(1'b1, 1);
        frame(8'h0F, 0, 7, 2);
        en_blank(1'b1, 5);
        chk("abort_matrix", matrix_o, 64'h08090A0B0C0D0E0F);
        chk("abort_cnt",    64'(frame_cnt_o), 64'd3);
        en_blank(1'b0, 3);

        // Reset mid-scan after 5 rows, then re-capture
        en_blank(1'b1, 1);
        frame(8'hE1, 0, 4, 2);
        pulse_reset();
        lit_zero("mid_reset");
        en_blank(1'b1, 1);
        frame(8'h99, 0, 7, 2);
        en_blank(1'b1, 5);
        chk("post_reset_matrix", matrix_o, 64'h9E9F9C9D9A9B9899);
        chk("post_reset_cnt",    64'(frame_cnt_o), 64'd1);

        // Back-to-back frames with enable held: counter wraps at 256 commits
        for (int i = 1; i <= 255; i++) begin
            frame(8'(i), 0, 7, 2);
            en_blank(1'b1, 5);
            if (i == 254) chk("wrap_cnt_255", 64'(frame_cnt_o), 64'd255);
        end
        chk("wrap_cnt_0",   64'(frame_cnt_o), 64'd0);
        chk("wrap_matrix",  matrix_o, 64'hF8F9FAFBFCFDFEFF);
        en_blank(1'b0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_scan_capture.md
Name: matrix_scan_capture

Overview:
- Receive side of the LED-matrix scan interface: samples the multiplexed col/row drive lines that the display stage emits and rebuilds the gs×gs frame.
- Output is the flat matrix vector in the same bit layout that action produces.
- Used as a loopback checker in the top level and as the frame input on a chained second board.
- Controlled by the standard enable/done handshake (e_cap_i / d_cap_o), so the top-level sequencer can slot it in as one more state.

Parameters:
- gs, 8: matrix edge length; row/col line width; frame is gs*gs bits.
- STABLE, 4: consecutive identical cycles required before a row sample is accepted (≥1).
- TIMEOUT, 4096: max cycles allowed to complete one frame once scanning starts (≥gs*STABLE).

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- e_cap_i  in  1  enable from sequencer; level, held until d_cap_o seen.
- col_val_i  in  gs  column drive; bit c=1 means pixel c lit in the active row.
- row_val_i  in  gs  row select; one-hot active-high; bit r=1 selects row r.
- matrix_o  out  gs*gs  last complete frame; matrix_o[r*gs+c] = pixel (r,c).
- d_cap_o  out  1  one-cycle done pulse when a new frame is committed.
- err_o  out  1  sticky: non-one-hot row seen or timeout; cleared only by reset.
- frame_cnt_o  out  8  committed-frame counter, wraps 255→0.

Behaviour:
- Reset (reset_i=1 at a clock edge): matrix_o=0, d_cap_o=0, err_o=0, frame_cnt_o=0, shadow buffer=0, row-captured mask=0, stable counter=0, timeout counter=0, state=IDLE. Reset overrides everything, including mid-frame; the partial frame is discarded.
- States:
  - IDLE: outputs held. e_cap_i=1 → SCAN, clearing the mask and timeout counter.
  - SCAN: samples lines every cycle. Mask all-ones → COMMIT. Timeout counter reaches TIMEOUT-1 → err_o=1, clear mask, remain in SCAN (restart frame). e_cap_i=0 → IDLE, partial frame discarded.
  - COMMIT: matrix_o ← shadow (atomic, all gs rows same edge), frame_cnt_o+1, d_cap_o=1 for this cycle only → DONE.
  - DONE: e_cap_i=0 → IDLE. e_cap_i still 1 for one cycle (sequencer lag) is tolerated. If e_cap_i is still 1 on the second cycle → SCAN, starting a new frame.
- Stability filter (SCAN only):
  - Registered previous (row,col) pair. If the current pair equals the previous pair, stable counter increments, saturating at STABLE. Otherwise the counter resets to 1.
  - A sample is accepted on the cycle the counter reaches STABLE. The same unchanged pair is accepted only once.
  - Accepted sample with one-hot row r: shadow row r ← col_val_i, mask[r]←1. A row captured twice in a frame is overwritten (latest wins).
  - Accepted sample with row_val_i=0 (blanking): ignored, no error.
  - Accepted sample with ≥2 row bits set: ignored, err_o←1.
- Latency: a row held stable for STABLE cycles is in the shadow on the next edge. The last row accepted → COMMIT next cycle → matrix_o/d_cap_o valid one cycle after COMMIT entry, i.e. 2 cycles after acceptance.
- Timeout counter: width $clog2(TIMEOUT); runs only in SCAN; cleared on entering SCAN and on each commit.
- Row index from one-hot by priority encoder; the encoder output is used only when one-hot is verified.

Test Plan:
- gs=8, STABLE=2: reset, e_cap_i=1, drive rows 0..7 one-hot, each 3 cycles with col=8'hA5^r → d_cap_o pulses once; matrix_o[r*8+:8]=8'hA5^r; frame_cnt_o=1; err_o=0.
- Row 3 held for only 1 cycle, other rows correct → no d_cap_o until row 3 is re-presented for ≥2 cycles; then commit with the row 3 value.
- row_val_i=8'b0001_1000 stable for 2 cycles mid-frame → err_o=1 and stays 1; frame still commits once all rows are seen validly; reset → err_o=0.
- TIMEOUT=64: only rows 0..6 driven → err_o=1 at cycle 64 of SCAN, mask cleared; matrix_o unchanged (previous frame) until a full frame is driven.
- Drop e_cap_i after 4 rows, reassert, drive 8 rows with new data → matrix_o shows only new data; no stale row from the aborted frame; frame_cnt_o increments by 1.
- reset_i pulsed mid-SCAN after 5 rows → all outputs 0 next cycle; the frame after re-enable commits correctly; 256 commits wrap frame_cnt_o to 0.
